writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Writeback stage of the RV32I core; the producer side of the decode-stage register-file write port.
- Accepts one retiring instruction per handshake from the memory stage.
- For loads, waits for the data-memory response with a bounded timeout, then aligns and extends the byte, half or word.
- Issues exactly one registered register-file write per retired instruction, suppressing writes to x0; counts retirements and flags load errors.

Parameters:
LOAD_TIMEOUT, 16, cycles spent in WAIT_LOAD without dmem_rvalid before the load is abandoned (minimum 2).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
mem_valid_i  in  1  memory stage presents a retiring instruction
mem_ready_o  out  1  writeback can accept an instruction
mem_reg_write_i  in  1  instruction writes rd
mem_rd_i  in  5  destination register id
mem_is_load_i  in  1  instruction is a load
mem_func3_i  in  3  load width/sign code
mem_addr_lo_i  in  2  byte offset of the load address
mem_result_i  in  32  ALU/link result for non-loads
mem_pc_i  in  32  PC, kept for debug
dmem_rvalid_i  in  1  load data valid, one-cycle pulse
dmem_rdata_i  in  32  raw word-aligned load data
WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT  out  1  register-file write enable
WRITEBACK_TO_DECODE_REG_ID_OUT  out  5  register-file write id
WRITEBACK_TO_DECODE_DATA_OUT  out  32  register-file write data
retire_o  out  1  one-cycle pulse per retired instruction
retire_pc_o  out  32  PC of the retiring instruction
retire_cnt_o  out  CNT_W  retired-instruction count, wraps
err_timeout_o  out  1  sticky: a load timed out
err_align_o  out  1  sticky: misaligned load or illegal load func3

Behaviour:
- FSM states: IDLE, WAIT_LOAD, COMMIT. Reset puts the FSM in IDLE and clears every output register, the counter, the captured fields and both sticky flags.
- mem_ready_o = (state==IDLE). A transfer occurs on mem_valid_i && mem_ready_o.
- IDLE, non-load accepted: capture rd, reg_write, pc and result; go to COMMIT.
- IDLE, load accepted: capture fields; clear the timeout counter; go to WAIT_LOAD.
- WAIT_LOAD, dmem_rvalid_i=1: extract the data (see below), go to COMMIT.
- WAIT_LOAD, no rvalid: increment the timeout counter. When it reaches LOAD_TIMEOUT-1, set err_timeout_o, mark the write suppressed and go to COMMIT.
- Load data extraction:
  - LB (000): rdata[8*lo+7:8*lo], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): lo[1] selects rdata[31:16] or rdata[15:0], sign-extended.
  - LHU (101): same half, zero-extended.
  - LW (010): full word.
- Alignment errors: LH/LHU with lo[0]=1, LW with lo!=0, or any other func3. Each sets err_align_o and suppresses the write, but the FSM still waits for rvalid or the timeout.
- COMMIT lasts exactly one cycle, with registered outputs:
  - WRITE_EN = reg_write && rd!=0 && !suppressed.
  - REG_ID = rd.
  - DATA = the result, or 0 when suppressed.
  - retire_o=1, retire_pc_o=pc, retire_cnt_o increments.
  - Next state is IDLE.
- In every other cycle WRITE_EN=0 and retire_o=0; REG_ID and DATA hold their last values.
- Latency:
  - Non-load accepted at cycle N: write visible at the clock edge ending N+1.
  - Load whose rvalid arrives at cycle M: write at M+1.
  - Throughput is one instruction per 2 cycles.
- dmem_rvalid_i seen in IDLE or COMMIT is ignored: no state change and no error.
- rvalid arriving in the same cycle as the timeout expiry takes precedence: data is used and no timeout error is raised.
- rst asserted mid-load drops the pending instruction with no write.
- retire_cnt_o wraps from all-ones to 0.
- The sticky error flags clear only on rst.

Decomposition:
- define.v gains:
  - load func3 constants: `LB, `LH, `LW, `LBU, `LHU;
  - state encodings: `WB_IDLE, `WB_WAIT_LOAD, `WB_COMMIT.
- One combinational sub-module, load_extract, holds the extraction and alignment check. Its inputs are func3, lo and rdata; its outputs are data and align_err.

Test Plan:
- Non-load: ADD result 0x0000_1234 to rd=5 → next cycle WRITE_EN=1, ID=5, DATA=0x1234, retire_o=1, cnt=1. Same instruction with rd=0 → WRITE_EN=0, retire_o=1.
- Signed loads: LB lo=3, rdata=0x80FF_0000 → DATA=0xFFFF_FF80. LBU same inputs → 0x0000_0080.
- Half and word loads: LH lo=2, rdata=0x8001_7FFF → 0xFFFF_8001. LHU lo=0, same rdata → 0x0000_7FFF. LW lo=0 → 0x8001_7FFF.
- Misaligned: LW lo=1 with rvalid after 3 cycles → err_align_o=1, WRITE_EN=0, retire_o=1, mem_ready_o back to 1 a cycle later.
- Timeout: load with no rvalid → COMMIT after LOAD_TIMEOUT-1 wait cycles, err_timeout_o=1, WRITE_EN=0. A later stray rvalid in IDLE causes no effect.
- Reset mid-load: rst asserted during WAIT_LOAD → no write, all outputs 0, mem_ready_o=1 the cycle after rst drops. Separately, a back-to-back valid stream retires one instruction every 2 cycles and the counter increments correctly.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback stage:
// load func3 codes, FSM states, captured request.
package writeback_unit_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_WAIT_LOAD,
    WB_COMMIT
  } wb_state_e;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [1:0]  lo;
    logic [31:0] pc;
  } wb_req_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Memory-stage -> writeback handshake bundle.
// master = memory stage, slave = writeback.
interface writeback_unit_if;

  logic        mem_valid_i;
  logic        mem_ready_o;
  logic        mem_reg_write_i;
  logic [4:0]  mem_rd_i;
  logic        mem_is_load_i;
  logic [2:0]  mem_func3_i;
  logic [1:0]  mem_addr_lo_i;
  logic [31:0] mem_result_i;
  logic [31:0] mem_pc_i;

  modport master (
    output mem_valid_i,
    input  mem_ready_o,
    output mem_reg_write_i,
    output mem_rd_i,
    output mem_is_load_i,
    output mem_func3_i,
    output mem_addr_lo_i,
    output mem_result_i,
    output mem_pc_i
  );

  modport slave (
    input  mem_valid_i,
    output mem_ready_o,
    input  mem_reg_write_i,
    input  mem_rd_i,
    input  mem_is_load_i,
    input  mem_func3_i,
    input  mem_addr_lo_i,
    input  mem_result_i,
    input  mem_pc_i
  );

endinterface

// File: rtl/writeback_unit_load_extract.sv
// Load data align/extend plus alignment check.
// in: func3, lo, rdata  out: data, align_err
module load_extract
  import writeback_unit_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic        align_err
);

  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;

  assign shifted = rdata >> {lo, 3'b000};
  assign b = shifted[7:0];
  assign h = lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data      = 32'h0;
    align_err = 1'b0;
    unique case (func3)
      LB:  data = {{24{b[7]}}, b};
      LBU: data = {24'h0, b};
      LH: begin
        data      = {{16{h[15]}}, h};
        align_err = lo[0];
      end
      LHU: begin
        data      = {16'h0, h};
        align_err = lo[0];
      end
      LW: begin
        data      = rdata;
        align_err = (lo != 2'b00);
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: retires one instr per handshake,
// drives the regfile write port, counts retires, flags load errors.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  writeback_unit_if.slave  mem,
  input  logic             dmem_rvalid_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT,
  output logic [4:0]       WRITEBACK_TO_DECODE_REG_ID_OUT,
  output logic [31:0]      WRITEBACK_TO_DECODE_DATA_OUT,
  output logic             retire_o,
  output logic [31:0]      retire_pc_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             err_timeout_o,
  output logic             err_align_o
);

  localparam int TW = $clog2(LOAD_TIMEOUT) + 1;

  wb_state_e    state_q, state_d;
  wb_req_t      req_q;
  logic [TW-1:0] tmo_q;

  logic        accept;
  logic        tmo_hit;
  logic [31:0] ld_data;
  logic        ld_err;

  logic        cm_we;
  logic [4:0]  cm_rd;
  logic [31:0] cm_data;
  logic [31:0] cm_pc;
  logic        cm_tmo;
  logic        cm_align;

  assign mem.mem_ready_o = (state_q == WB_IDLE);
  assign accept  = mem.mem_valid_i && (state_q == WB_IDLE);
  // Fires on the (LOAD_TIMEOUT-1)th wait cycle.
  assign tmo_hit = (tmo_q == TW'(LOAD_TIMEOUT - 2));

  load_extract u_extract (
    .func3     (req_q.func3),
    .lo        (req_q.lo),
    .rdata     (dmem_rdata_i),
    .data      (ld_data),
    .align_err (ld_err)
  );

  // Commit values are computed on the cycle before COMMIT
  // and registered on entry, so the write is live in COMMIT.
  always_comb begin
    state_d  = state_q;
    cm_we    = 1'b0;
    cm_rd    = req_q.rd;
    cm_data  = 32'h0;
    cm_pc    = req_q.pc;
    cm_tmo   = 1'b0;
    cm_align = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (accept) begin
          if (mem.mem_is_load_i) begin
            state_d = WB_WAIT_LOAD;
          end else begin
            state_d = WB_COMMIT;
            cm_rd   = mem.mem_rd_i;
            cm_pc   = mem.mem_pc_i;
            cm_data = mem.mem_result_i;
            cm_we   = mem.mem_reg_write_i
                      && (mem.mem_rd_i != 5'd0);
          end
        end
      end
      WB_WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          state_d  = WB_COMMIT;
          cm_align = ld_err;
          cm_data  = ld_err ? 32'h0 : ld_data;
          cm_we    = req_q.reg_write && (req_q.rd != 5'd0)
                     && !ld_err;
        end else if (tmo_hit) begin
          state_d  = WB_COMMIT;
          cm_tmo   = 1'b1;
          cm_align = ld_err;
        end
      end
      WB_COMMIT: state_d = WB_IDLE;
      default:   state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WB_IDLE;
      req_q         <= '0;
      tmo_q         <= '0;
      retire_o      <= 1'b0;
      retire_pc_o   <= 32'h0;
      retire_cnt_o  <= '0;
      err_timeout_o <= 1'b0;
      err_align_o   <= 1'b0;
      WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT <= 1'b0;
      WRITEBACK_TO_DECODE_REG_ID_OUT       <= 5'd0;
      WRITEBACK_TO_DECODE_DATA_OUT         <= 32'h0;
    end else begin
      state_q  <= state_d;
      retire_o <= 1'b0;
      WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT <= 1'b0;
      if (accept) begin
        req_q.reg_write <= mem.mem_reg_write_i;
        req_q.rd        <= mem.mem_rd_i;
        req_q.func3     <= mem.mem_func3_i;
        req_q.lo        <= mem.mem_addr_lo_i;
        req_q.pc        <= mem.mem_pc_i;
        tmo_q           <= '0;
      end else if (state_q == WB_WAIT_LOAD && !dmem_rvalid_i) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (state_d == WB_COMMIT) begin
        retire_o     <= 1'b1;
        retire_pc_o  <= cm_pc;
        retire_cnt_o <= retire_cnt_o + CNT_W'(1);
        WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT <= cm_we;
        WRITEBACK_TO_DECODE_REG_ID_OUT       <= cm_rd;
        WRITEBACK_TO_DECODE_DATA_OUT         <= cm_data;
        if (cm_tmo)   err_timeout_o <= 1'b1;
        if (cm_align) err_align_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit:
// vector table plus multi-cycle corner sequences.
module tb_writeback_unit;

  localparam int LT = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          dmem_rvalid;
  logic [31:0]   dmem_rdata;
  logic          we;
  logic [4:0]    rid;
  logic [31:0]   wdata;
  logic          retire;
  logic [31:0]   rpc;
  logic [CW-1:0] rcnt;
  logic          etmo;
  logic          ealign;

  int checks   = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  writeback_unit_if mif ();

  writeback_unit #(
    .LOAD_TIMEOUT (LT),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (mif),
    .dmem_rvalid_i (dmem_rvalid),
    .dmem_rdata_i  (dmem_rdata),
    .WRITEBACK_TO_DECODE_REG_WRITE_EN_OUT (we),
    .WRITEBACK_TO_DECODE_REG_ID_OUT       (rid),
    .WRITEBACK_TO_DECODE_DATA_OUT         (wdata),
    .retire_o      (retire),
    .retire_pc_o   (rpc),
    .retire_cnt_o  (rcnt),
    .err_timeout_o (etmo),
    .err_align_o   (ealign)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] res;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [4:0] rd,
                       input logic rw, input logic [31:0] res,
                       input logic [31:0] pc);
    mif.mem_valid_i     = 1'b1;
    mif.mem_is_load_i   = ld;
    mif.mem_func3_i     = f3;
    mif.mem_addr_lo_i   = lo;
    mif.mem_rd_i        = rd;
    mif.mem_reg_write_i = rw;
    mif.mem_result_i    = res;
    mif.mem_pc_i        = pc;
  endtask

  task automatic check_commit(input string tag, input logic e_we,
                              input logic [4:0] e_id,
                              input logic [31:0] e_data,
                              input logic [31:0] e_pc);
    exp_cnt = exp_cnt + 1'b1;
    chk({tag, ".we"},     32'(we),     32'(e_we));
    chk({tag, ".id"},     32'(rid),    32'(e_id));
    chk({tag, ".data"},   wdata,       e_data);
    chk({tag, ".retire"}, 32'(retire), 32'd1);
    chk({tag, ".pc"},     rpc,         e_pc);
    chk({tag, ".cnt"},    32'(rcnt),   32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{1'b0, 3'b000, 2'd0, 5'd5, 1'b1, 32'h0000_1234,
              32'h0, 1'b1, 32'h0000_1234};
    vt[1] = '{1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 32'h0000_1234,
              32'h0, 1'b0, 32'h0000_1234};
    vt[2] = '{1'b1, 3'b000, 2'd3, 5'd7, 1'b1, 32'h0,
              32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
    vt[3] = '{1'b1, 3'b100, 2'd3, 5'd7, 1'b1, 32'h0,
              32'h80FF_0000, 1'b1, 32'h0000_0080};
    vt[4] = '{1'b1, 3'b001, 2'd2, 5'd8, 1'b1, 32'h0,
              32'h8001_7FFF, 1'b1, 32'hFFFF_8001};
    vt[5] = '{1'b1, 3'b101, 2'd0, 5'd8, 1'b1, 32'h0,
              32'h8001_7FFF, 1'b1, 32'h0000_7FFF};
    vt[6] = '{1'b1, 3'b010, 2'd0, 5'd9, 1'b1, 32'h0,
              32'h8001_7FFF, 1'b1, 32'h8001_7FFF};
    vt[7] = '{1'b1, 3'b000, 2'd1, 5'd2, 1'b1, 32'h0,
              32'h0000_7F00, 1'b1, 32'h0000_007F};
    vt[8] = '{1'b0, 3'b000, 2'd0, 5'd3, 1'b0, 32'hDEAD_BEEF,
              32'h0, 1'b0, 32'hDEAD_BEEF};

    rst         = 1'b1;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    issue(1'b0, 3'b0, 2'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    mif.mem_valid_i = 1'b0;
    exp_cnt = '0;
    tick();
    tick();
    chk("rst.we",     32'(we),     32'd0);
    chk("rst.retire", 32'(retire), 32'd0);
    chk("rst.cnt",    32'(rcnt),   32'd0);
    chk("rst.data",   wdata,       32'd0);
    chk("rst.etmo",   32'(etmo),   32'd0);
    chk("rst.ealign", 32'(ealign), 32'd0);
    chk("rst.ready",  32'(mif.mem_ready_o), 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      issue(vt[i].ld, vt[i].f3, vt[i].lo, vt[i].rd, vt[i].rw,
            vt[i].res, 32'h100 + 32'(i * 4));
      tick();
      mif.mem_valid_i = 1'b0;
      if (vt[i].ld) begin
        chk($sformatf("v%0d.busy", i), 32'(mif.mem_ready_o), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = vt[i].rdata;
        tick();
        dmem_rvalid = 1'b0;
      end
      check_commit($sformatf("v%0d", i), vt[i].exp_we, vt[i].rd,
                   vt[i].exp_data, 32'h100 + 32'(i * 4));
      tick();
      chk($sformatf("v%0d.ready", i), 32'(mif.mem_ready_o), 32'd1);
      chk($sformatf("v%0d.off", i), 32'(retire), 32'd0);
    end
    chk("vec.ealign", 32'(ealign), 32'd0);

    // rvalid lands on the expiry cycle: data wins
    issue(1'b1, 3'b010, 2'd0, 5'd4, 1'b1, 32'h0, 32'h180);
    tick();
    mif.mem_valid_i = 1'b0;
    repeat (LT - 2) tick();
    chk("prec.wait", 32'(retire), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    check_commit("prec", 1'b1, 5'd4, 32'hCAFE_F00D, 32'h180);
    chk("prec.etmo", 32'(etmo), 32'd0);
    tick();

    // misaligned LW, rvalid on third wait cycle
    issue(1'b1, 3'b010, 2'd1, 5'd6, 1'b1, 32'h0, 32'h200);
    tick();
    mif.mem_valid_i = 1'b0;
    tick();
    tick();
    chk("mis.wait",  32'(retire), 32'd0);
    chk("mis.busy",  32'(mif.mem_ready_o), 32'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check_commit("mis", 1'b0, 5'd6, 32'h0, 32'h200);
    chk("mis.ealign", 32'(ealign), 32'd1);
    chk("mis.etmo",   32'(etmo),   32'd0);
    tick();
    chk("mis.ready", 32'(mif.mem_ready_o), 32'd1);

    // timeout with no rvalid
    issue(1'b1, 3'b010, 2'd0, 5'd9, 1'b1, 32'h0, 32'h300);
    tick();
    mif.mem_valid_i = 1'b0;
    n = 0;
    while (!retire && n < 40) begin
      tick();
      n++;
    end
    chk("tmo.cycles", 32'(n), 32'(LT - 1));
    check_commit("tmo", 1'b0, 5'd9, 32'h0, 32'h300);
    chk("tmo.etmo",   32'(etmo),   32'd1);
    chk("tmo.ealign", 32'(ealign), 32'd1);
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    chk("stray.retire", 32'(retire), 32'd0);
    chk("stray.we",     32'(we),     32'd0);
    chk("stray.ready",  32'(mif.mem_ready_o), 32'd1);
    chk("stray.cnt",    32'(rcnt),   32'(exp_cnt));
    chk("stray.data",   wdata,       32'h0);

    // reset during WAIT_LOAD drops the load
    issue(1'b1, 3'b000, 2'd0, 5'd8, 1'b1, 32'h0, 32'h400);
    tick();
    mif.mem_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    exp_cnt = '0;
    chk("rml.we",     32'(we),     32'd0);
    chk("rml.retire", 32'(retire), 32'd0);
    chk("rml.id",     32'(rid),    32'd0);
    chk("rml.data",   wdata,       32'd0);
    chk("rml.pc",     rpc,         32'd0);
    chk("rml.cnt",    32'(rcnt),   32'd0);
    chk("rml.etmo",   32'(etmo),   32'd0);
    chk("rml.ealign", 32'(ealign), 32'd0);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("rml.ready",  32'(mif.mem_ready_o), 32'd1);
    chk("rml.noret",  32'(retire), 32'd0);
    chk("rml.nowe",   32'(we),     32'd0);

    // back-to-back stream, counter wraps at CW bits
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, 3'b000, 2'd0, 5'(10 + i), 1'b1,
            32'h11 * 32'(i + 1), 32'h500 + 32'(i * 4));
      tick();
      check_commit($sformatf("b2b%0d", i), 1'b1, 5'(10 + i),
                   32'h11 * 32'(i + 1), 32'h500 + 32'(i * 4));
      tick();
      chk($sformatf("b2b%0d.gap", i), 32'(retire), 32'd0);
      chk($sformatf("b2b%0d.rdy", i), 32'(mif.mem_ready_o), 32'd1);
    end
    mif.mem_valid_i = 1'b0;
    chk("b2b.wrap", 32'(rcnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
